sprite_renderer: RTL and testbench

SPRITE_RENDERER -- requirements
Module: sprite_renderer

---
 rtl/sprite_render_pkg.sv | 17 +
 rtl/pixel_fifo.sv | 61 ++++++
 rtl/sprite_renderer.sv | 185 ++++++++++++++++++
 tb/tb_sprite_renderer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_render_pkg.sv
// rtl/sprite_render_pkg.sv - shared types and LCD constants for the sprite renderer
package sprite_render_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RENDER = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int          LCD_WIDTH           = 240;
    localparam int          LCD_HEIGHT          = 320;
    localparam logic [15:0] DEFAULT_TRANSPARENT = 16'hF81F;

    // FIFO entry layout: {x[7:0], y[8:0], rgb565[15:0]}
    localparam int PIXEL_W = 33;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - small synchronous FIFO buffering pixels towards the LCD writer
module pixel_fifo
    import sprite_render_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PIXEL_W,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - walks a sprite in ROM and streams visible, non-key pixels to the LCD
module sprite_renderer
    import sprite_render_pkg::*;
#(
    parameter logic [15:0] TRANSPARENT  = DEFAULT_TRANSPARENT,
    parameter int          READ_LATENCY = 2,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  spriteId,
    input  logic [7:0]  spriteX,
    input  logic [8:0]  spriteY,
    input  logic [7:0]  spriteWidth,
    input  logic [8:0]  spriteHeight,
    output logic        busy,
    output logic        done,
    output logic [3:0]  ROMId,
    output logic [15:0] ROMAddr,
    input  logic [15:0] ReadROMOut,
    output logic [7:0]  pixelX,
    output logic [8:0]  pixelY,
    output logic [15:0] pixelData,
    output logic        pixelValid,
    input  logic        pixelReady
);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int LAST = READ_LATENCY - 1;

    state_t        state;
    logic [7:0]    x0;
    logic [8:0]    y0;
    logic [7:0]    w;
    logic [8:0]    h;
    logic [7:0]    col;
    logic [8:0]    row;
    logic [15:0]   next_addr;

    // a_* travels with ROMAddr; p_* is the tag pipeline lined up with ReadROMOut
    logic          a_valid;
    logic [8:0]    a_x;
    logic [9:0]    a_y;
    logic          p_valid [READ_LATENCY];
    logic [8:0]    p_x     [READ_LATENCY];
    logic [9:0]    p_y     [READ_LATENCY];

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [PIXEL_W-1:0] fifo_head;

    logic [7:0]    pending;
    logic          pipe_busy;
    logic          issue;
    logic          last_pos;

    // Reads in flight plus buffered pixels, crediting the pop happening this cycle,
    // so a steady stream keeps the FIFO from ever overflowing at full throughput.
    always_comb begin
        pending   = {7'd0, a_valid};
        pipe_busy = a_valid;
        for (int i = 0; i < READ_LATENCY; i++) begin
            pending   = pending + {7'd0, p_valid[i]};
            pipe_busy = pipe_busy | p_valid[i];
        end
        pending = pending + 8'(fifo_count) - {7'd0, fifo_pop};
    end

    assign issue    = (state == RENDER) && (pending < 8'(FIFO_DEPTH));
    assign last_pos = (col == w - 8'd1) && (row == h - 9'd1);

    assign fifo_push = p_valid[LAST]
                    && (ReadROMOut != TRANSPARENT)
                    && (p_x[LAST] < 9'(LCD_WIDTH))
                    && (p_y[LAST] < 10'(LCD_HEIGHT))
                    && !fifo_full;
    assign fifo_pop  = pixelValid && pixelReady;

    assign busy       = (state != IDLE);
    assign pixelValid = !fifo_empty;
    assign pixelX     = fifo_head[32:25];
    assign pixelY     = fifo_head[24:16];
    assign pixelData  = fifo_head[15:0];

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W),
        .CW    (CW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({p_x[LAST][7:0], p_y[LAST][8:0], ReadROMOut}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            ROMId     <= '0;
            ROMAddr   <= '0;
            x0        <= '0;
            y0        <= '0;
            w         <= '0;
            h         <= '0;
            col       <= '0;
            row       <= '0;
            next_addr <= '0;
            a_valid   <= 1'b0;
            a_x       <= '0;
            a_y       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                p_valid[i] <= 1'b0;
                p_x[i]     <= '0;
                p_y[i]     <= '0;
            end
        end else begin
            done       <= 1'b0;
            a_valid    <= issue;
            p_valid[0] <= a_valid;
            p_x[0]     <= a_x;
            p_y[0]     <= a_y;
            for (int i = 1; i < READ_LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_x[i]     <= p_x[i-1];
                p_y[i]     <= p_y[i-1];
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (spriteWidth == 8'd0 || spriteHeight == 9'd0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RENDER;
                            ROMId     <= spriteId;
                            x0        <= spriteX;
                            y0        <= spriteY;
                            w         <= spriteWidth;
                            h         <= spriteHeight;
                            col       <= '0;
                            row       <= '0;
                            next_addr <= '0;
                        end
                    end
                end
                RENDER: begin
                    if (issue) begin
                        ROMAddr   <= next_addr;
                        next_addr <= next_addr + 16'd1;
                        a_x       <= {1'b0, x0} + {1'b0, col};
                        a_y       <= {1'b0, y0} + {1'b0, row};
                        if (col == w - 8'd1) begin
                            col <= '0;
                            row <= row + 9'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                        if (last_pos) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_busy && fifo_empty) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        ROMId   <= '0;
                        ROMAddr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// tb/tb_sprite_renderer.sv - randomized self-checking bench for sprite_renderer
module tb_sprite_renderer;
    localparam logic [15:0] TRANS = 16'hF81F;
    localparam int          DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  spriteId;
    logic [7:0]  spriteX;
    logic [8:0]  spriteY;
    logic [7:0]  spriteWidth;
    logic [8:0]  spriteHeight;
    logic        busy;
    logic        done;
    logic [3:0]  ROMId;
    logic [15:0] ROMAddr;
    logic [15:0] ReadROMOut;
    logic [7:0]  pixelX;
    logic [8:0]  pixelY;
    logic [15:0] pixelData;
    logic        pixelValid;
    logic        pixelReady;

    always #5 clock = ~clock;

    sprite_renderer #(
        .TRANSPARENT  (TRANS),
        .READ_LATENCY (2),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .spriteId     (spriteId),
        .spriteX      (spriteX),
        .spriteY      (spriteY),
        .spriteWidth  (spriteWidth),
        .spriteHeight (spriteHeight),
        .busy         (busy),
        .done         (done),
        .ROMId        (ROMId),
        .ROMAddr      (ROMAddr),
        .ReadROMOut   (ReadROMOut),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .pixelData    (pixelData),
        .pixelValid   (pixelValid),
        .pixelReady   (pixelReady)
    );

    // ROM reader model: two register stages between address and data
    logic [15:0] rom_mem [256];
    logic [15:0] rom_d1;
    logic [15:0] rom_d2;
    assign ReadROMOut = rom_d2;
    always @(posedge clock) begin
        rom_d1 <= rom_mem[ROMAddr[7:0]];
        rom_d2 <= rom_d1;
    end

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [15:0] addr_seen[$];
    int          recv = 0;
    int          done_cnt = 0;
    int          max_out = 0;
    int          ready_mode = 0;
    logic [3:0]  cur_id = '0;
    logic        prev_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_pix = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_rom(input int pct_trans);
        logic [15:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            if (v == TRANS) v = v ^ 16'h0001;
            if (int'($urandom_range(0, 99)) < pct_trans) v = TRANS;
            rom_mem[i] = v;
        end
    endtask

    // Reference: every sprite cell in raster order, kept if visible and not the key colour
    task automatic start_sprite(input logic [3:0] id, input logic [7:0] x, input logic [8:0] y,
                                input logic [7:0] w, input logic [8:0] h);
        int          sx;
        int          sy;
        logic [15:0] d;
        exp_q.delete();
        addr_seen.delete();
        recv    = 0;
        max_out = 0;
        cur_id  = id;
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
                sx = int'(x) + c;
                sy = int'(y) + r;
                d  = rom_mem[8'(r * int'(w) + c)];
                if (d != TRANS && sx < 240 && sy < 320) exp_q.push_back({sx[7:0], sy[8:0], d});
            end
        end
        @(posedge clock);
        #1;
        start        = 1'b1;
        spriteId     = id;
        spriteX      = x;
        spriteY      = y;
        spriteWidth  = w;
        spriteHeight = h;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_sprite(input int base, input int n_addr);
        int i = 0;
        while (done_cnt == base && i < 3000) begin
            @(negedge clock);
            i++;
        end
        check("done_seen", 64'(done_cnt != base), 64'd1);
        repeat (5) @(negedge clock);
        check("done_count", 64'(done_cnt - base), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("pixels_missing", 64'(exp_q.size()), 64'd0);
        check("addr_count", 64'(addr_seen.size()), 64'(n_addr));
        for (int k = 0; k < addr_seen.size(); k++) check("addr_seq", 64'(addr_seen[k]), 64'(k));
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        case (ready_mode)
            0:       pixelReady = 1'b1;
            1:       pixelReady = ($urandom_range(0, 3) != 0);
            default: pixelReady = 1'b0;
        endcase
    end

    // Monitor: scoreboard, hold-while-stalled, done width, address trace, ROMId
    initial forever begin
        @(negedge clock);
        if (reset) begin
            if (done) begin
                done_cnt++;
                check("done_single_cycle", 64'(prev_done), 64'd0);
            end
            if (prev_stall) begin
                check("hold_valid", 64'(pixelValid), 64'd1);
                check("hold_pixel", 64'({pixelX, pixelY, pixelData}), 64'(prev_pix));
            end
            if (pixelValid && pixelReady) begin
                check("pixel_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("pixel", 64'({pixelX, pixelY, pixelData}), 64'(exp_q.pop_front()));
                recv++;
            end
            if (busy) begin
                if (addr_seen.size() == 0 || ROMAddr != addr_seen[addr_seen.size()-1])
                    addr_seen.push_back(ROMAddr);
                check("rom_id", 64'(ROMId), 64'(cur_id));
                if (addr_seen.size() - recv > max_out) max_out = addr_seen.size() - recv;
            end
        end
        prev_done  = done;
        prev_stall = reset && pixelValid && !pixelReady;
        prev_pix   = {pixelX, pixelY, pixelData};
    end

    initial begin
        int base;
        int r0;
        logic [7:0] rw;
        logic [8:0] rh;
        reset        = 1'b0;
        start        = 1'b0;
        spriteId     = '0;
        spriteX      = '0;
        spriteY      = '0;
        spriteWidth  = '0;
        spriteHeight = '0;
        pixelReady   = 1'b1;
        fill_rom(0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr", 64'(ROMAddr), 64'd0);
        check("rst_id", 64'(ROMId), 64'd0);
        check("rst_valid", 64'(pixelValid), 64'd0);
        check("rst_pixel", 64'({pixelX, pixelY, pixelData}), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // 2x2 at (10,20): latency and order
        fill_rom(0);
        base = done_cnt;
        start_sprite(4'd3, 8'd10, 9'd20, 8'd2, 9'd2);
        @(negedge clock);
        check("t_busy", 64'(busy), 64'd1);
        check("t_valid_n0", 64'(pixelValid), 64'd0);
        @(negedge clock);
        @(negedge clock);
        check("t_addr1", 64'(ROMAddr), 64'd1);
        @(negedge clock);
        check("t_valid_n3", 64'(pixelValid), 64'd0);
        @(negedge clock);
        check("t_valid_n4", 64'(pixelValid), 64'd1);
        check("t_first_xy", 64'({pixelX, pixelY}), 64'({8'd10, 9'd20}));
        finish_sprite(base, 4);
        check("t_count", 64'(recv), 64'd4);

        // 4x1 with key colour in word 2
        fill_rom(0);
        rom_mem[2] = TRANS;
        base = done_cnt;
        start_sprite(4'd1, 8'd50, 9'd60, 8'd4, 9'd1);
        finish_sprite(base, 4);
        check("key_count", 64'(recv), 64'd3);

        // 4x4 straddling the bottom-right corner
        fill_rom(0);
        base = done_cnt;
        start_sprite(4'd5, 8'd238, 9'd318, 8'd4, 9'd4);
        finish_sprite(base, 16);
        check("clip_count", 64'(recv), 64'd4);

        // 8x8 with a 20-cycle stall mid-frame
        fill_rom(0);
        base = done_cnt;
        start_sprite(4'd7, 8'd100, 9'd100, 8'd8, 9'd8);
        repeat (10) @(posedge clock);
        ready_mode = 2;
        repeat (20) @(posedge clock);
        ready_mode = 0;
        finish_sprite(base, 64);
        check("stall_count", 64'(recv), 64'd64);
        check("stall_max_out", 64'(max_out), 64'(DEPTH));

        // reset mid-render, then a 1x1 sprite
        fill_rom(0);
        base = done_cnt;
        start_sprite(4'd2, 8'd30, 9'd40, 8'd6, 9'd6);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(pixelValid), 64'd0);
        check("mid_rst_id", 64'(ROMId), 64'd0);
        exp_q.delete();
        r0 = recv;
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (10) @(negedge clock);
        check("mid_rst_no_pixel", 64'(recv), 64'(r0));
        check("mid_rst_no_done", 64'(done_cnt), 64'(base));
        base = done_cnt;
        start_sprite(4'd4, 8'd5, 9'd6, 8'd1, 9'd1);
        finish_sprite(base, 1);
        check("one_pixel", 64'(recv), 64'd1);

        // zero-size sprites
        base = done_cnt;
        start_sprite(4'd1, 8'd10, 9'd10, 8'd0, 9'd5);
        @(negedge clock);
        check("zero_w_done", 64'(done), 64'd1);
        check("zero_w_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clock);
        check("zero_w_pulses", 64'(done_cnt - base), 64'd1);
        check("zero_w_pixels", 64'(recv), 64'd0);
        check("zero_w_addrs", 64'(addr_seen.size()), 64'd0);
        base = done_cnt;
        start_sprite(4'd1, 8'd10, 9'd10, 8'd5, 9'd0);
        @(negedge clock);
        check("zero_h_done", 64'(done), 64'd1);
        repeat (5) @(negedge clock);
        check("zero_h_pixels", 64'(recv), 64'd0);

        // second start while busy is ignored
        fill_rom(0);
        base = done_cnt;
        start_sprite(4'd2, 8'd7, 9'd8, 8'd3, 9'd3);
        repeat (2) @(posedge clock);
        #1;
        start       = 1'b1;
        spriteId    = 4'd9;
        spriteX     = 8'd0;
        spriteWidth = 8'd5;
        @(posedge clock);
        #1 start = 1'b0;
        finish_sprite(base, 9);
        check("ignore_count", 64'(recv), 64'd9);

        // randomized sprites, placement and backpressure
        ready_mode = 1;
        for (int t = 0; t < 10; t++) begin
            fill_rom(20);
            rw = 8'($urandom_range(1, 12));
            rh = 9'($urandom_range(1, 12));
            base = done_cnt;
            start_sprite(4'($urandom_range(0, 15)),
                         ($urandom_range(0, 1) != 0) ? 8'($urandom_range(228, 255)) : 8'($urandom_range(0, 255)),
                         ($urandom_range(0, 1) != 0) ? 9'($urandom_range(308, 330)) : 9'($urandom_range(0, 511)),
                         rw, rh);
            finish_sprite(base, int'(rw) * int'(rh));
        end
        ready_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
